fp_div_mantissa_iter: RTL and testbench
=======================================

// Module: fp_div_mantissa_iter
// PURPOSE
//  Iterative radix-2 restoring mantissa divider for the FP32 divide pipeline. It sits directly
//  downstream of the special-case/exponent stage and consumes its registered outputs: mantissas
//  with the hidden bit restored, the exponent difference, the sign and the special-case result.
//  It produces a 27-bit quotient plus sticky and an exponent adjusted for normalisation, which
//  feed the rounding/packing stage. The divider is not pipelined: one operation is in flight at a time.
// PARAMETERS
//  MANT_W   24  mantissa width including the hidden bit
//  QBITS    27  quotient bits produced: 1 integer bit, 26 fraction bits (24 + guard + round)
//  EXP_W    10  signed exponent width carried through the block
// PORTS
//  clk                 in   1       clock, rising edge
//  rst                 in   1       asynchronous reset, active-low (rst=0 resets)
//  in_valid            in   1       upstream operands valid
//  in_ready            out  1       block can accept an operand (high only in IDLE)
//  in_mant_a           in   MANT_W  dividend mantissa {1,frac}
//  in_mant_b           in   MANT_W  divisor mantissa {1,frac}
//  in_exp              in   EXP_W   signed exponent difference from the upstream stage
//  in_sign             in   1       result sign
//  in_rounding_mode    in   3       rounding mode (fp_pkg encoding), passed through
//  in_special_case     in   1       upstream special result applies; bypass the iteration
//  in_special_result   in   32      packed special result, passed through
//  in_invalid          in   1       invalid-operation flag, passed through
//  in_flushed          in   1       denormal-flushed flag, passed through
//  in_div_by_zero      in   1       divisor zero/denormal and the operation is not invalid; bypass
//  out_valid           out  1       result valid; held until accepted
//  out_ready           in   1       downstream accepts
//  out_quot            out  QBITS   raw quotient q[26:0]; q[26] is the integer bit
//  out_sticky          out  1       OR of the final partial remainder (remainder != 0)
//  out_exp             out  EXP_W   in_exp if q[26]=1, else in_exp-1
//  out_sign, out_rounding_mode, out_special_case, out_special_result, out_invalid,
//  out_flushed, out_div_by_zero  out  (as inputs)  registered copies captured at accept
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, all outputs and internal registers 0, except in_ready=1.
//  - Accept occurs when in_valid & in_ready; all inputs are captured into sideband registers that
//    cycle. No input is sampled outside the accept cycle.
//  - FSM: IDLE -> ITER on accept when in_special_case=0 and in_div_by_zero=0.
//    IDLE -> DONE on accept when either bypass input is 1.
//    ITER -> DONE after QBITS iteration cycles.
//    DONE -> IDLE when out_ready=1; the block stays in DONE while out_ready=0.
//  - Datapath: R is a (MANT_W+1)-bit partial remainder, initialised to {0,in_mant_a}; D=in_mant_b.
//    Each ITER cycle: if R>=D then qbit=1, R=(R-D)<<1; else qbit=0, R=R<<1. qbit shifts into the
//    quotient LSB. The iteration counter runs 0..QBITS-1. The MSB-first first bit is the integer bit.
//  - sticky = (R!=0) after the last iteration. The quotient is in [0.5,2), so q[26]|q[25] is always 1.
//  - Bypass: quotient=0, sticky=0, out_exp=in_exp. Sideband is passed unchanged. The downstream
//    stage forms +/-inf or the special result.
//  - Latency: accept at cycle t -> out_valid at t+QBITS+1 (normal) or t+1 (bypass).
//    Throughput: one operation per QBITS+2 cycles with out_ready held at 1.
//  - out_valid is 1 only in DONE. Outputs are stable while out_valid=1 and out_ready=0.
//  - in_ready is 0 in ITER and DONE. No new accept is possible in the cycle DONE->IDLE
//    (no same-cycle turnaround).
//  - Reset asserted mid-ITER or in DONE aborts the operation. No out_valid is produced for it.
//  - Exponent arithmetic is signed EXP_W. The decrement does not saturate; range checks are done downstream.
// STRUCTURE
//  - fp_pkg gains: a typedef enum for div_iter_state_t {IDLE,ITER,DONE}, localparam FP_QBITS=27, and
//    a packed struct fp_div_side_t (sign, exp, rounding_mode, special_case, special_result, flags).
//  - One sub-module: fp_div_restore_step (combinational compare/subtract/shift of R, D -> R', qbit).
//    The FSM, counter and sideband registers live in the top module.
// TESTING
//  - 0x800000 / 0x800000 (1.0/1.0), exp 0 -> out_quot=27'h4000000, sticky 0, out_exp 0,
//    out_valid at t+28.
//  - 0x800000 / 0xC00000 (1.0/1.5), exp 5 -> out_quot=27'h2AAAAAA, sticky 1, out_exp 4.
//  - 0xC00000 / 0x800000 (1.5/1.0) -> out_quot=27'h6000000, sticky 0. Hold out_ready=0 for 10 cycles:
//    out_valid and outputs stay stable and in_ready stays 0; accept on out_ready=1, then IDLE.
//  - in_special_case=1, special_result=32'h7FC00000 -> out_valid at t+1, out_quot=0, result passed through.
//    in_div_by_zero=1 -> same timing, out_div_by_zero=1.
//  - Drop rst to 0 at iteration 10 -> out_valid=0 and in_ready=1 immediately. A subsequent 1.0/1.0
//    operation is correct.
//  - Back-to-back random mantissas vs reference model (a<<26)/b: quotient and sticky are exact, and
//    in_ready never asserts during ITER or DONE.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP32 divide-pipeline types: mantissa-divider FSM states, quotient width and the
// sideband bundle carried alongside the iterative divider.
package fp_pkg;

  localparam int unsigned FP_QBITS = 27;
  localparam int unsigned FP_EXP_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_iter_state_t;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [2:0]          rounding_mode;
    logic                special_case;
    logic [31:0]         special_result;
    logic                invalid;
    logic                flushed;
    logic                div_by_zero;
  } fp_div_side_t;

endpackage

// File: rtl/fp_div_restore_step.sv
// One radix-2 restoring division step: compare partial remainder against the divisor,
// conditionally subtract, and shift left by one.
module fp_div_restore_step #(
  parameter int unsigned W = 24
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] div_i,
  output logic [W:0]   rem_o,
  output logic         qbit_o
);

  logic [W:0] div_ext;
  logic [W:0] sel;

  always_comb begin
    div_ext = {1'b0, div_i};
    qbit_o  = (rem_i >= div_ext);
    sel     = qbit_o ? (rem_i - div_ext) : rem_i;
    // After a restoring step sel < div, so the shifted value always fits in W+1 bits.
    rem_o   = sel << 1;
  end

endmodule

// File: rtl/fp_div_mantissa_iter.sv
// Iterative radix-2 restoring mantissa divider: produces a 27-bit quotient, sticky and a
// normalisation-adjusted exponent, one operation in flight at a time.
module fp_div_mantissa_iter
  import fp_pkg::*;
#(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned QBITS  = FP_QBITS,
  parameter int unsigned EXP_W  = FP_EXP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MANT_W-1:0]       in_mant_a,
  input  logic [MANT_W-1:0]       in_mant_b,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic                    in_sign,
  input  logic [2:0]              in_rounding_mode,
  input  logic                    in_special_case,
  input  logic [31:0]             in_special_result,
  input  logic                    in_invalid,
  input  logic                    in_flushed,
  input  logic                    in_div_by_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [QBITS-1:0]        out_quot,
  output logic                    out_sticky,
  output logic signed [EXP_W-1:0] out_exp,
  output logic                    out_sign,
  output logic [2:0]              out_rounding_mode,
  output logic                    out_special_case,
  output logic [31:0]             out_special_result,
  output logic                    out_invalid,
  output logic                    out_flushed,
  output logic                    out_div_by_zero
);

  localparam int unsigned CntW = $clog2(QBITS);
  localparam logic [CntW-1:0] CntLast = CntW'(QBITS - 1);
  localparam logic [EXP_W-1:0] ExpOne = EXP_W'(1);

  div_iter_state_t   state_q, state_d;
  logic [MANT_W:0]   rem_q, rem_d, rem_step;
  logic [MANT_W-1:0] div_q, div_d;
  logic [QBITS-1:0]  quot_q, quot_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  fp_div_side_t      side_q, side_d;
  logic              qbit;

  fp_div_restore_step #(
    .W (MANT_W)
  ) u_step (
    .rem_i  (rem_q),
    .div_i  (div_q),
    .rem_o  (rem_step),
    .qbit_o (qbit)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    side_d  = side_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          side_d = '{sign:           in_sign,
                     exp:            in_exp,
                     rounding_mode:  in_rounding_mode,
                     special_case:   in_special_case,
                     special_result: in_special_result,
                     invalid:        in_invalid,
                     flushed:        in_flushed,
                     div_by_zero:    in_div_by_zero};
          div_d  = in_mant_b;
          quot_d = '0;
          cnt_d  = '0;
          if (in_special_case || in_div_by_zero) begin
            // Bypass: zero remainder keeps sticky clear, exponent passes unadjusted.
            rem_d   = '0;
            state_d = DONE;
          end else begin
            rem_d   = {1'b0, in_mant_a};
            state_d = ITER;
          end
        end
      end
      ITER: begin
        rem_d  = rem_step;
        quot_d = {quot_q[QBITS-2:0], qbit};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = DONE;
          // Quotient below 1.0 needs one left normalisation shift downstream.
          if (!quot_d[QBITS-1]) begin
            side_d.exp = side_q.exp - ExpOne;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      side_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      side_q  <= side_d;
    end
  end

  assign in_ready           = (state_q == IDLE);
  assign out_valid          = (state_q == DONE);
  assign out_quot           = quot_q;
  assign out_sticky         = |rem_q;
  assign out_exp            = side_q.exp;
  assign out_sign           = side_q.sign;
  assign out_rounding_mode  = side_q.rounding_mode;
  assign out_special_case   = side_q.special_case;
  assign out_special_result = side_q.special_result;
  assign out_invalid        = side_q.invalid;
  assign out_flushed        = side_q.flushed;
  assign out_div_by_zero    = side_q.div_by_zero;

endmodule

// File: tb/tb_fp_div_mantissa_iter.sv
// Self-checking bench for the iterative mantissa divider: directed vector table, corner
// sequences (hold, bypass, mid-iteration reset) and random operations against a model.
module tb_fp_div_mantissa_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [23:0] in_mant_a, in_mant_b;
  logic [9:0]  in_exp;
  logic        in_sign;
  logic [2:0]  in_rounding_mode;
  logic        in_special_case;
  logic [31:0] in_special_result;
  logic        in_invalid, in_flushed, in_div_by_zero;
  logic        out_valid, out_ready;
  logic [26:0] out_quot;
  logic        out_sticky;
  logic [9:0]  out_exp;
  logic        out_sign;
  logic [2:0]  out_rounding_mode;
  logic        out_special_case;
  logic [31:0] out_special_result;
  logic        out_invalid, out_flushed, out_div_by_zero;

  fp_div_mantissa_iter dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_mant_a          (in_mant_a),
    .in_mant_b          (in_mant_b),
    .in_exp             (in_exp),
    .in_sign            (in_sign),
    .in_rounding_mode   (in_rounding_mode),
    .in_special_case    (in_special_case),
    .in_special_result  (in_special_result),
    .in_invalid         (in_invalid),
    .in_flushed         (in_flushed),
    .in_div_by_zero     (in_div_by_zero),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_quot           (out_quot),
    .out_sticky         (out_sticky),
    .out_exp            (out_exp),
    .out_sign           (out_sign),
    .out_rounding_mode  (out_rounding_mode),
    .out_special_case   (out_special_case),
    .out_special_result (out_special_result),
    .out_invalid        (out_invalid),
    .out_flushed        (out_flushed),
    .out_div_by_zero    (out_div_by_zero)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int ready_viol = 0;

  // Sideband values driven at the most recent accept.
  logic        e_sign, e_sc, e_inv, e_fl, e_dz;
  logic [2:0]  e_rm;
  logic [31:0] e_sr;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [9:0]  e;
    logic [26:0] q;
    logic        sticky;
    logic [9:0]  oexp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: quotient is floor(a * 2^26 / b); sticky when the division is inexact.
  task automatic model(input logic [23:0] a, input logic [23:0] b, input logic [9:0] e,
                       output logic [26:0] q, output logic st, output logic [9:0] oe);
    longint unsigned num, qq;
    num = longint'(a) << 26;
    qq  = num / longint'(b);
    q   = qq[26:0];
    st  = (num % longint'(b)) != 0;
    oe  = (qq >= (64'd1 << 26)) ? e : e - 10'd1;
  endtask

  task automatic start_op(input logic [23:0] a, input logic [23:0] b, input logic [9:0] e,
                          input logic sc, input logic dz, input logic [31:0] sr);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", 64'(in_ready), 64'd1);
    e_sign = 1'($urandom); e_rm = 3'($urandom); e_inv = 1'($urandom); e_fl = 1'($urandom);
    e_sc = sc; e_dz = dz; e_sr = sr;
    in_mant_a = a; in_mant_b = b; in_exp = e; in_special_case = sc; in_div_by_zero = dz;
    in_special_result = sr; in_sign = e_sign; in_rounding_mode = e_rm;
    in_invalid = e_inv; in_flushed = e_fl;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Garbage after accept: nothing may be sampled outside the accept cycle.
    in_mant_a = 24'($urandom); in_mant_b = 24'($urandom); in_exp = 10'($urandom);
    in_sign = ~e_sign; in_rounding_mode = ~e_rm; in_special_case = 1'($urandom);
    in_special_result = $urandom; in_invalid = ~e_inv; in_flushed = ~e_fl;
    in_div_by_zero = 1'($urandom);
  endtask

  // Returns the cycle (relative to accept cycle t) in which out_valid is first seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_viol++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) chk("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic chk_side();
    chk("sign", 64'(out_sign), 64'(e_sign));
    chk("rmode", 64'(out_rounding_mode), 64'(e_rm));
    chk("special_case", 64'(out_special_case), 64'(e_sc));
    chk("special_result", 64'(out_special_result), 64'(e_sr));
    chk("invalid", 64'(out_invalid), 64'(e_inv));
    chk("flushed", 64'(out_flushed), 64'(e_fl));
    chk("div_by_zero", 64'(out_div_by_zero), 64'(e_dz));
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_done_valid", 64'(out_valid), 64'd0);
    chk("post_done_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic [26:0] mq;
    logic        ms;
    logic [9:0]  me;
    logic [23:0] ra, rb;
    logic [9:0]  re;

    vecs[0] = '{24'h800000, 24'h800000, 10'd0,   27'h4000000, 1'b0, 10'd0};
    vecs[1] = '{24'h800000, 24'hC00000, 10'd5,   27'h2AAAAAA, 1'b1, 10'd4};
    vecs[2] = '{24'hC00000, 24'h800000, 10'd3,   27'h6000000, 1'b0, 10'd3};
    vecs[3] = '{24'hFFFFFF, 24'h800000, 10'd7,   27'h7FFFFF8, 1'b0, 10'd7};
    vecs[4] = '{24'h800000, 24'hFFFFFF, 10'd0,   27'h2000002, 1'b1, 10'h3FF};
    vecs[5] = '{24'h800000, 24'hC00000, 10'h200, 27'h2AAAAAA, 1'b1, 10'h1FF};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mant_a = '0; in_mant_b = '0; in_exp = '0; in_sign = 1'b0; in_rounding_mode = '0;
    in_special_case = 1'b0; in_special_result = '0; in_invalid = 1'b0; in_flushed = 1'b0;
    in_div_by_zero = 1'b0;
    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_quot", 64'(out_quot), 64'd0);
    chk("reset_exp", 64'(out_exp), 64'd0);
    chk("reset_sticky", 64'(out_sticky), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].e, 1'b0, 1'b0, 32'h0);
      wait_valid(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd28);
      chk($sformatf("vec%0d_quot", i), 64'(out_quot), 64'(vecs[i].q));
      chk($sformatf("vec%0d_sticky", i), 64'(out_sticky), 64'(vecs[i].sticky));
      chk($sformatf("vec%0d_exp", i), 64'(out_exp), 64'(vecs[i].oexp));
      chk_side();
      if (i == 2) begin
        for (int c = 0; c < 10; c++) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_quot", 64'(out_quot), 64'h6000000);
          chk("hold_in_ready", 64'(in_ready), 64'd0);
          @(posedge clk); #1;
        end
      end
      finish_op();
    end

    // Bypass paths: special result and divide-by-zero.
    start_op(24'hC00000, 24'h800000, 10'd9, 1'b1, 1'b0, 32'h7FC00000);
    wait_valid(lat);
    chk("special_latency", 64'(lat), 64'd1);
    chk("special_quot", 64'(out_quot), 64'd0);
    chk("special_sticky", 64'(out_sticky), 64'd0);
    chk("special_exp", 64'(out_exp), 64'd9);
    chk_side();
    finish_op();
    start_op(24'hA00000, 24'h000000, 10'h3F0, 1'b0, 1'b1, 32'h0);
    wait_valid(lat);
    chk("dz_latency", 64'(lat), 64'd1);
    chk("dz_quot", 64'(out_quot), 64'd0);
    chk("dz_exp", 64'(out_exp), 64'h3F0);
    chk_side();
    finish_op();

    // Reset at iteration 10 aborts the operation.
    start_op(24'h800000, 24'hC00000, 10'd5, 1'b0, 1'b0, 32'h0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_quot", 64'(out_quot), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;
    start_op(24'h800000, 24'h800000, 10'd0, 1'b0, 1'b0, 32'h0);
    wait_valid(lat);
    chk("post_abort_latency", 64'(lat), 64'd28);
    chk("post_abort_quot", 64'(out_quot), 64'h4000000);
    chk("post_abort_sticky", 64'(out_sticky), 64'd0);
    finish_op();

    // Random back-to-back operations with random downstream stalls.
    for (int k = 0; k < 40; k++) begin
      ra = {1'b1, 23'($urandom)};
      rb = {1'b1, 23'($urandom)};
      re = 10'($urandom);
      model(ra, rb, re, mq, ms, me);
      start_op(ra, rb, re, 1'b0, 1'b0, 32'h0);
      wait_valid(lat);
      chk("rand_latency", 64'(lat), 64'd28);
      chk("rand_quot", 64'(out_quot), 64'(mq));
      chk("rand_sticky", 64'(out_sticky), 64'(ms));
      chk("rand_exp", 64'(out_exp), 64'(me));
      chk("rand_norm", 64'(out_quot[26] | out_quot[25]), 64'd1);
      repeat ($urandom_range(0, 3)) begin
        chk("rand_stall_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
      end
      chk("rand_stall_quot", 64'(out_quot), 64'(mq));
      finish_op();
    end

    chk("in_ready_while_busy", 64'(ready_viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
